ip_fifo_wr_arb: RTL and testbench
=================================

# ip_fifo_wr_arb

Round-robin write-port arbiter that shares one `ip_fifo` write port among N requesters. Each requester presents a valid/ready/last stream. The arbiter registers a one-hot grant and steers the granted requester's data onto the FIFO's `wr_en`/`din`, throttled by the FIFO's `full`. It sits directly in front of the FIFO write side and runs in the FIFO write-clock domain.

## Interface
- `N`, 4, number of requesters (2..8)
- `WIDTH`, 8, data width; must equal the FIFO `WIDTH`
- `MAX_BURST`, 4, maximum beats per grant in lock mode (1..16)

Ports:
- `clk`  in  1  write clock, rising edge (connects to FIFO `wr_clk`)
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  N  per-requester beat valid
- `req_data`  in  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
- `req_last`  in  N  final beat of a burst (used only in lock mode)
- `req_ready`  out  N  beat accepted when `req_valid[i] & req_ready[i]`
- `fifo_full`  in  1  from FIFO `full`
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_din`  out  WIDTH  to FIFO `din`
- `grant`  out  N  registered one-hot owner; all-zero when idle
- `busy`  out  1  state is GRANT

## Operation
- State machine: IDLE, GRANT.
- Registers:
  - `grant` (N)
  - `rr_ptr` (clog2 N), the highest-priority index
  - `beat_cnt` (clog2 MAX_BURST + 1)
  - state
- Arbitration picks the first `i` with `req_valid[i]` set, scanning `rr_ptr`, `rr_ptr+1`, … mod N.
- IDLE:
  - If any `req_valid` is set, register grant to the picked index, clear `beat_cnt`, and go to GRANT.
  - Otherwise stay in IDLE with `grant`=0.
- GRANT, with granted index g:
  - `req_ready[g]` = !`fifo_full`. All other `req_ready` are 0.
  - `fifo_wr_en` = `req_valid[g]` & !`fifo_full`.
  - `fifo_din` = `req_data[g]`.
  - A beat is any cycle in which `fifo_wr_en`=1. Each beat increments `beat_cnt`.
- Release condition:
  - Lock mode: release on a beat where `req_last[g]`=1, or where `beat_cnt`+1 == `MAX_BURST`.
  - Otherwise: release on any beat.
  - Release additionally (both modes) when `req_valid[g]`=0 in GRANT and no beat has occurred in the current grant.
- On release:
  - `rr_ptr` ← (g+1) mod N.
  - Arbitration is re-run at the same edge, with the new pointer, over `req_valid` excluding g. Beats from other requesters therefore go back-to-back with no bubble.
  - If no other requester is valid, go to IDLE (`grant`←0). g must then wait one IDLE cycle before it is granted again.
- `fifo_full` stalls a grant indefinitely; it never causes a release.
- A requester deasserting valid mid-burst in lock mode keeps the grant: the burst is held open.

## Timing
- Reset (`rst_n`=0, asynchronous) forces state=IDLE, `grant`=0, `rr_ptr`=0, `beat_cnt`=0, `busy`=0, `req_ready`=0, `fifo_wr_en`=0, `fifo_din`=0.
- Reset asserted mid-burst drops the grant immediately. A beat in that cycle is not written.
- Latency: `req_valid` rising in IDLE at cycle 0 → `grant` at edge 1 → earliest FIFO write at edge 2.
- Back-to-back across requesters sustains 1 beat/cycle.
- `fifo_wr_en`, `fifo_din` and `req_ready` are combinational from registered `grant` and from `req_valid`/`fifo_full`. There is no path from `req_data` to any control output.
- `fifo_din` is 0 whenever `grant`=0.

## Configuration
- `IP_FIFO_WR_ARB_LOCK_EN` defined:
  - A grant is held for a burst, ending on `req_last`, `MAX_BURST` beats, or an empty first cycle.
  - `beat_cnt` is implemented.
- Not defined:
  - Each grant lasts exactly one beat; `req_last` is ignored.
  - `MAX_BURST` has no effect and `beat_cnt` is removed.

## Test plan
- Reset check: hold `rst_n`=0 with all `req_valid`=1. Required: `grant`=0, `fifo_wr_en`=0 and `req_ready`=0. Releasing reset gives `grant`=4'b0001 one edge later.
- Fairness (lock undefined, N=4): all four requesters valid continuously with `fifo_full`=0. Required: writes cycle through requesters 0,1,2,3,0… one beat per cycle, and `fifo_din` matches each requester's data.
- Full stall: requester 2 is granted and `fifo_full`=1 for 5 cycles. Required: `fifo_wr_en`=0 and `req_ready[2]`=0 throughout, and the grant is held. The beat is written on the first cycle with `fifo_full`=0.
- Burst lock (`IP_FIFO_WR_ARB_LOCK_EN`, `MAX_BURST`=4): requesters 0 and 1 are both valid, 0 sends 6 beats with no `req_last`. Required: 4 beats from 0, then 1 is granted with no bubble, and 0 resumes after 1 releases.
- Early last (lock defined): requester 3 asserts `req_last` on beat 2. Required: release after 2 beats and `rr_ptr`=0.
- Wrap and idle: only requester 3 is valid, with `rr_ptr`=3. Required: grant 3, one beat, then IDLE for one cycle, then regrant 3. `rr_ptr` wraps to 0.

Source files
------------

// File: rtl/ip_fifo_wr_arb.sv
// Round-robin arbiter sharing one ip_fifo write port among N valid/ready requesters.
// Define IP_FIFO_WR_ARB_LOCK_EN to hold a grant for a burst (req_last / MAX_BURST).
module ip_fifo_wr_arb #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_din,
  output logic [N-1:0]       grant,
  output logic               busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a beat transfers on a cycle where req_valid[i] & req_ready[i];
  // the same cycle raises fifo_wr_en, and valid must not depend on ready.
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [PW-1:0]  g_idx;
  logic [PW-1:0]  rr_next;
  logic           g_valid;
  logic           release_now;
  logic [N-1:0]   pick_idle;
  logic [N-1:0]   pick_rel;

  // One-hot of the first set mask bit scanning ptr, ptr+1, ... mod N.
  function automatic logic [N-1:0] rr_pick(input logic [PW-1:0] ptr, input logic [N-1:0] mask);
    logic [N-1:0] res;
    logic         found;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && (i == ((int'(ptr) + k) % N)) && mask[i]) begin
          res[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    fifo_din = '0;
    g_valid  = 1'b0;
    g_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        fifo_din = req_data[i*WIDTH +: WIDTH];
        g_valid  = req_valid[i];
        g_idx    = PW'(i);
      end
    end
  end

  assign req_ready  = grant_q & {N{~fifo_full}};
  assign fifo_wr_en = g_valid & ~fifo_full;
  assign grant      = grant_q;
  assign busy       = (state_q == ST_GRANT);
  assign rr_next    = (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;
  assign pick_idle  = rr_pick(rr_ptr_q, req_valid);
  // Re-arbitration at release skips the outgoing owner so others go back-to-back.
  assign pick_rel   = rr_pick(rr_next, req_valid & ~grant_q);

`ifdef IP_FIFO_WR_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST) + 1;

  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          g_last;

  always_comb begin
    g_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) g_last = req_last[i];
    end
  end

  assign release_now = (fifo_wr_en && (g_last || ((int'(beat_cnt_q) + 1) == MAX_BURST)))
                     || (!g_valid && (beat_cnt_q == '0));

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == ST_IDLE || release_now) begin
      beat_cnt_d = '0;
    end else if (fifo_wr_en) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end
`else
  logic unused_cfg;

  // Single-beat grants: any beat, or an empty granted cycle, ends the grant.
  assign release_now = fifo_wr_en || !g_valid;
  assign unused_cfg  = ^{req_last, (MAX_BURST > 0)};
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (|req_valid) begin
          state_d = ST_GRANT;
          grant_d = pick_idle;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          rr_ptr_d = rr_next;
          if (|pick_rel) begin
            grant_d = pick_rel;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_ip_fifo_wr_arb.sv
// Self-checking bench for ip_fifo_wr_arb: directed plan items plus randomized traffic
// against an index-level reference model of the arbitration rules.
module tb_ip_fifo_wr_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_din;
  logic [N-1:0]   grant;
  logic           busy;

  ip_fifo_wr_arb #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant      (grant),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  bit           sb_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;

  function automatic int first_from(input int start, input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_step
    int           o;
    int           p;
    int           b;
    bit           beat;
    bit           rel;
    logic [N-1:0] mask;
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_beats <= 0;
    end else begin
      o = m_owner;
      p = m_ptr;
      b = m_beats;
      if (o < 0) begin
        o = first_from(p, req_valid);
        b = 0;
      end else begin
        beat = req_valid[o] && !fifo_full;
`ifdef IP_FIFO_WR_ARB_LOCK_EN
        rel = (beat && (req_last[o] || (b + 1 == MB))) || (!req_valid[o] && b == 0);
`else
        rel = beat || !req_valid[o];
`endif
        if (beat) b = b + 1;
        if (rel) begin
          p       = (o + 1) % N;
          mask    = req_valid;
          mask[o] = 1'b0;
          o       = first_from(p, mask);
          b       = 0;
        end
      end
      m_owner <= o;
      m_ptr   <= p;
      m_beats <= b;
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin : compare
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic [W-1:0] e_din;
    e_grant = '0;
    e_ready = '0;
    e_wr    = 1'b0;
    e_din   = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_ready          = fifo_full ? '0 : e_grant;
      e_wr             = req_valid[m_owner] && !fifo_full;
      e_din            = req_data[m_owner*W +: W];
    end
    check("model_grant", 64'(grant), 64'(e_grant));
    check("model_req_ready", 64'(req_ready), 64'(e_ready));
    check("model_wr_en", 64'(fifo_wr_en), 64'(e_wr));
    check("model_din", 64'(fifo_din), 64'(e_din));
    check("model_busy", 64'(busy), 64'(m_owner >= 0));
    if (sb_en && fifo_wr_en) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 64'(fifo_din), 64'hFFFF_FFFF);
      else check("sb_write_data", 64'(fifo_din), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(32'hA0 + i);
  endtask

  task automatic drive_random();
    req_valid = N'($urandom_range(0, (1 << N) - 1));
    req_last  = N'($urandom_range(0, (1 << N) - 1));
    fifo_full = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_valid = '1;
    req_last  = '1;
    fifo_full = 1'b0;
    set_fixed_data();
    #1 rst_n = 1'b0;

    // reset held with all requesters valid
    repeat (3) @(negedge clk);
    check("reset_grant", 64'(grant), 64'h0);
    check("reset_wr_en", 64'(fifo_wr_en), 64'h0);
    check("reset_req_ready", 64'(req_ready), 64'h0);
    check("reset_din", 64'(fifo_din), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);

    // fairness: 12 single beats rotating 0,1,2,3
    sb_en = 1'b1;
    for (int k = 0; k < 12; k++) exp_q.push_back(8'hA0 + 8'(k % 4));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("grant_after_reset", 64'(grant), 64'h1);
    repeat (12) @(posedge clk);
    #1 req_valid = '0;
    repeat (3) tick();
    check("fair_sb_drained", 64'(exp_q.size()), 64'h0);

    // full stall on requester 2
    req_valid = 4'b0100;
    fifo_full = 1'b1;
    exp_q.push_back(8'hA2);
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("stall_grant", 64'(grant), 64'h4);
      check("stall_wr_en", 64'(fifo_wr_en), 64'h0);
      check("stall_ready2", 64'(req_ready[2]), 64'h0);
    end
    @(posedge clk);
    #1 fifo_full = 1'b0;
    @(negedge clk);
    check("stall_release_wr", 64'(fifo_wr_en), 64'h1);
    check("stall_release_din", 64'(fifo_din), 64'hA2);

    // wrap and idle: only requester 3, pointer now 3
    @(posedge clk);
    #1 req_valid = 4'b1000;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA3);
    @(negedge clk);
    check("wrap_idle_first", 64'(grant), 64'h0);
    @(negedge clk);
    check("wrap_grant3", 64'(grant), 64'h8);
    check("wrap_wr3", 64'(fifo_wr_en), 64'h1);
    @(negedge clk);
    check("wrap_idle_gap", 64'(grant), 64'h0);
    @(negedge clk);
    check("wrap_regrant3", 64'(grant), 64'h8);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) tick();
    check("wrap_sb_drained", 64'(exp_q.size()), 64'h0);

    // pointer wrapped to 0: with 0 and 3 both valid, 0 wins
    sb_en     = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    check("wrap_ptr_zero", 64'(grant), 64'h1);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) tick();

`ifdef IP_FIFO_WR_ARB_LOCK_EN
    // burst lock: requester 0 sends 6 beats without last, MAX_BURST=4
    sb_en     = 1'b1;
    req_last  = 4'b0010;
    req_valid = 4'b0011;
    repeat (4) exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    repeat (3) exp_q.push_back(8'hA0);
    repeat (5) @(negedge clk);
    check("burst_fourth_beat0", 64'(grant), 64'h1);
    @(negedge clk);
    check("burst_grant1_nobubble", 64'(grant), 64'h2);
    check("burst_wr1", 64'(fifo_wr_en), 64'h1);
    @(posedge clk);
    #1 req_valid = 4'b0001;
    @(negedge clk);
    check("burst_resume0", 64'(grant), 64'h1);
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("burst_held_open", 64'(grant), 64'h1);
    @(posedge clk);
    #1 req_valid = 4'b0001;
    req_last = 4'b0001;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("burst_closed", 64'(grant), 64'h0);
    check("burst_sb_drained", 64'(exp_q.size()), 64'h0);

    // early last on beat 2 of requester 3; pointer must become 0
    tick();
    req_valid = 4'b1000;
    req_last  = 4'b0000;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA3);
    @(posedge clk);
    #1 req_valid = 4'b1011;
    @(negedge clk);
    check("early_grant3", 64'(grant), 64'h8);
    @(posedge clk);
    #1 req_last = 4'b1000;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("early_last_ptr0", 64'(grant), 64'h1);
    repeat (3) tick();
    check("early_sb_drained", 64'(exp_q.size()), 64'h0);
    sb_en    = 1'b0;
    req_last = '1;
`endif

    // reset asserted mid-grant drops everything at once
    req_valid = '1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_grant", 64'(grant), 64'h0);
    check("midreset_wr_en", 64'(fifo_wr_en), 64'h0);
    check("midreset_din", 64'(fifo_din), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // randomized traffic checked against the model each cycle
    repeat (3000) begin
      tick();
      drive_random();
    end
    tick();
    req_valid = '0;
    fifo_full = 1'b0;
    repeat (MB + 4) tick();
    check("final_idle_grant", 64'(grant), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
